// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and
// pipeline_hazard_ctrl (slave): register indices and stage flags in,
// forwarding selects and stall/flush controls out.
interface pipeline_hazard_ctrl_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       ResultSrcE;
  logic       PCSrcE;
  logic       LongOpE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       StallE;
  logic       FlushD;
  logic       FlushE;
  logic       FlushM;
  logic       LongDone;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, LongOpE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, LongDone
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, LongOpE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, LongDone
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V core.
// Forwarding selects, load-use / branch stall-flush generation, and an
// IDLE/BUSY sequencer that freezes F/D/E while a multi-cycle op sits in E.
// Optional macro HAZARD_PERF_CNT_EN adds the StallCycles counter port.
// Controls are decoded combinationally from the registered sequencer state
// and the current stage inputs, so they act in the same cycle the hazard
// is visible.
module pipeline_hazard_ctrl #(
  parameter int unsigned LONG_LAT = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             StallCycles
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic               lw_stall;
  logic               long_start;

  // Forwarding select for one operand; Memory stage beats Writeback
  function automatic logic [1:0] fwd_sel(input logic       wr_m,
                                         input logic [4:0] rd_m,
                                         input logic       wr_w,
                                         input logic [4:0] rd_w,
                                         input logic [4:0] rs);
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                             return 2'b00;
  endfunction

  // Load in E whose destination is read by the instruction in D
  assign lw_stall = hz.ResultSrcE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // A long op starts in IDLE unless it is being flushed by a taken branch;
  // the completion cycle still holds the finishing op in E, so it cannot restart
  assign long_start = (state_q == IDLE) && !done_q && hz.LongOpE && !hz.PCSrcE;

  // Sequencer: the entry cycle counts as the first of LONG_LAT, the done
  // cycle as the last; BUSY covers the LONG_LAT-2 cycles in between
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (long_start) begin
            if (LONG_LAT <= 2) begin
              done_q <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_W'(LONG_LAT - 2);
            end
          end
        end
        BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Control decode; everything is forced low while reset is held
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.LongDone  = 1'b0;
    if (rst) begin
      hz.ForwardAE = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs1E);
      hz.ForwardBE = fwd_sel(hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW, hz.Rs2E);
      if (state_q == BUSY) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.FlushM = 1'b1;
      end else begin
        hz.StallF   = long_start || (lw_stall && !hz.PCSrcE);
        hz.StallD   = long_start || (lw_stall && !hz.PCSrcE);
        hz.StallE   = long_start;
        hz.FlushM   = long_start;
        hz.FlushD   = hz.PCSrcE;
        hz.FlushE   = (hz.PCSrcE || lw_stall) && !long_start;
        hz.LongDone = done_q;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Count of cycles Decode was held; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) StallCycles <= 32'd0;
    else if (hz.StallD) StallCycles <= StallCycles + 32'd1;
  end
`endif

endmodule
